// File: rtl/apb_wait_slave_mem.sv
// APB3 completer: word memory with WAIT_STATES stall cycles before PReady and PSlvErr
// on out-of-range addresses. Define APB_SLV_STRB_EN to add PStrb byte-lane writes.
module apb_wait_slave_mem #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] PAddr,
  input  logic [DATA_W-1:0] PWData,
  input  logic              PWrite,
  input  logic              PSel,
  input  logic              PEnable,
`ifdef APB_SLV_STRB_EN
  input  logic [DATA_W/8-1:0] PStrb,
`endif
  output logic [DATA_W-1:0] PRData,
  output logic              PReady,
  output logic              PSlvErr
);
  localparam int NB = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              commit;
  logic [NB-1:0]     wstrb;
`ifdef APB_SLV_STRB_EN
  logic [NB-1:0]     strb_q, strb_d;
  assign wstrb = strb_q;
`else
  assign wstrb = '1;
`endif

  // With zero wait states the response is loaded on the setup edge, so the
  // lookup must come straight off the bus while IDLE.
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_err;
  logic [DATA_W-1:0] rd_word;
  assign rd_addr = (state_q == IDLE) ? PAddr : addr_q;
  assign rd_err  = {1'b0, rd_addr} >= DEPTH_L;
  assign rd_word = rd_err ? '0 : mem[rd_addr[IDX_W-1:0]];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    cnt_d     = cnt_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    commit    = 1'b0;
`ifdef APB_SLV_STRB_EN
    strb_d    = strb_q;
`endif
    case (state_q)
      IDLE: begin
        if (PSel && !PEnable) begin
          state_d = ACCESS;
          addr_d  = PAddr;
          wdata_d = PWData;
          write_d = PWrite;
          cnt_d   = WS;
`ifdef APB_SLV_STRB_EN
          strb_d  = PStrb;
`endif
          if (WS == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = rd_err;
            if (!PWrite) prdata_d = rd_word;
          end
        end
      end
      ACCESS: begin
        if (!PSel) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (PEnable) begin
          if (pready_q) begin
            commit    = write_q && !rd_err;
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
          end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              pready_d  = 1'b1;
              pslverr_d = rd_err;
              if (!write_q) prdata_d = rd_word;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
`ifdef APB_SLV_STRB_EN
      strb_q    <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
`ifdef APB_SLV_STRB_EN
      strb_q    <= strb_d;
`endif
      if (commit)
        for (int b = 0; b < NB; b++)
          if (wstrb[b]) mem[addr_q[IDX_W-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  assign PRData  = prdata_q;
  assign PReady  = pready_q;
  assign PSlvErr = pslverr_q;
endmodule

// File: tb/tb_apb_wait_slave_mem.sv
// Bench for apb_wait_slave_mem: two instances (0 and 3 wait states) driven by directed
// and random APB transfers, checked against an array model of the memory.
module tb_apb_wait_slave_mem;
  logic clk = 1'b0;
  logic Rst;
  always #5 clk = ~clk;

  logic [15:0] paddr  [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic [3:0]  pstrb  [2];
  logic [1:0]  psel, pen, pwr, pready, perr;

  int ws [2] = '{0, 3};
  logic [31:0] mdl [2][256];
  int total = 0, passed = 0, failed = 0;

  apb_wait_slave_mem #(.WAIT_STATES(0)) u0 (
    .clk(clk), .Rst(Rst), .PAddr(paddr[0]), .PWData(pwdata[0]), .PWrite(pwr[0]),
    .PSel(psel[0]), .PEnable(pen[0]),
`ifdef APB_SLV_STRB_EN
    .PStrb(pstrb[0]),
`endif
    .PRData(prdata[0]), .PReady(pready[0]), .PSlvErr(perr[0]));

  apb_wait_slave_mem #(.WAIT_STATES(3)) u1 (
    .clk(clk), .Rst(Rst), .PAddr(paddr[1]), .PWData(pwdata[1]), .PWrite(pwr[1]),
    .PSel(psel[1]), .PEnable(pen[1]),
`ifdef APB_SLV_STRB_EN
    .PStrb(pstrb[1]),
`endif
    .PRData(prdata[1]), .PReady(pready[1]), .PSlvErr(perr[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] getmem(input int d, input int i);
    return (d == 0) ? u0.mem[i] : u1.mem[i];
  endfunction

  // Byte-lane merge of a committed write into the model word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
`ifdef APB_SLV_STRB_EN
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
`else
    r = wd;
    if (st == 4'hF) r = wd;
`endif
    return r;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) for (int i = 0; i < 256; i++) mdl[d][i] = '0;
  endtask

  task automatic cmp_mem(input int d, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (getmem(d, i) !== mdl[d][i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic bus_idle(input int d);
    psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0;
    paddr[d] = '0; pwdata[d] = '0; pstrb[d] = 4'hF;
  endtask

  // One full transfer. With b2b set the setup phase is driven on the same negedge
  // the previous transfer ended, i.e. the cycle right after its completion edge.
  task automatic xfer(input int d, input bit wr, input logic [15:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input bit b2b);
    bit err;
    logic [31:0] exp_rd;
    err = (a >= 16'd256);
    exp_rd = err ? 32'h0 : mdl[d][a[7:0]];
    if (!b2b) @(negedge clk);
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    @(negedge clk);
    pen[d] = 1'b1;
    paddr[d] = 16'($urandom); pwdata[d] = $urandom; pstrb[d] = 4'($urandom);
    for (int k = 0; k < ws[d]; k++) begin
      chk("stall_ready", {31'b0, pready[d]}, 32'h0);
      @(negedge clk);
    end
    chk("ready", {31'b0, pready[d]}, 32'h1);
    chk("slverr", {31'b0, perr[d]}, {31'b0, err});
    if (!wr) chk("rdata", prdata[d], exp_rd);
    @(negedge clk);
    psel[d] = 1'b0; pen[d] = 1'b0;
    chk("ready_drop", {31'b0, pready[d]}, 32'h0);
    if (wr && !err) mdl[d][a[7:0]] = merge(mdl[d][a[7:0]], wd, st);
  endtask

  initial begin
    logic [31:0] pre;
    clear_model();
    bus_idle(0); bus_idle(1);
    Rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'b0, pready[d]}, 32'h0);
      chk("rst_err", {31'b0, perr[d]}, 32'h0);
      chk("rst_rdata", prdata[d], 32'h0);
    end
    Rst = 1'b1;

    // zero-wait write, then the same word on the stalled instance
    xfer(0, 1'b1, 16'h50, 32'h50, 4'hF, 1'b0);
    chk("t1_mem", getmem(0, 'h50), 32'h50);
    xfer(1, 1'b1, 16'h50, 32'h50, 4'hF, 1'b0);
    xfer(1, 1'b0, 16'h50, 32'h0, 4'hF, 1'b0);

    // out-of-range write dropped, read returns zero with error
    xfer(0, 1'b1, 16'h100, 32'h1234, 4'hF, 1'b0);
    cmp_mem(0, "t3_mem_untouched");
    xfer(0, 1'b0, 16'h100, 32'h0, 4'hF, 1'b0);

    // abort after one stall cycle: no PReady, no write
    @(negedge clk);
    psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b1; paddr[1] = 16'h10; pwdata[1] = 32'hDEAD;
    @(negedge clk);
    pen[1] = 1'b1;
    chk("abort_stall", {31'b0, pready[1]}, 32'h0);
    @(negedge clk);
    psel[1] = 1'b0; pen[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_noready", {31'b0, pready[1]}, 32'h0);
    end
    chk("abort_mem", getmem(1, 'h10), 32'h0);
    xfer(1, 1'b1, 16'h10, 32'h1, 4'hF, 1'b0);
    chk("abort_retry_mem", getmem(1, 'h10), 32'h1);

    // access phase without setup is ignored
    @(negedge clk);
    psel[0] = 1'b1; pen[0] = 1'b1; paddr[0] = 16'h50;
    repeat (2) begin
      @(negedge clk);
      chk("noset_ready", {31'b0, pready[0]}, 32'h0);
    end
    bus_idle(0);

    // byte strobes
    xfer(0, 1'b1, 16'h20, 32'h11223344, 4'hF, 1'b0);
    xfer(0, 1'b1, 16'h20, 32'hAABBCCDD, 4'b0010, 1'b1);
`ifdef APB_SLV_STRB_EN
    chk("strb_mem", getmem(0, 'h20), 32'h1122CC44);
`else
    chk("strb_mem", getmem(0, 'h20), 32'hAABBCCDD);
`endif

    // random traffic, often back-to-back, with some out-of-range addresses
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        logic [15:0] a;
        a = 16'($urandom_range(0, 300));
        if (n % 3 == 0) a = 16'($urandom_range(0, 7));
        xfer(d, 1'($urandom), a, $urandom, 4'($urandom), 1'($urandom));
      end
      bus_idle(d);
      cmp_mem(d, "rand_mem");
    end

    // reset mid-wait: prdata[1] currently holds earlier read data
    xfer(1, 1'b0, 16'h50, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b1; paddr[1] = 16'h50; pwdata[1] = 32'h77;
    @(negedge clk);
    pen[1] = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'b0, pready[1]}, 32'h0);
    chk("midrst_err", {31'b0, perr[1]}, 32'h0);
    chk("midrst_rdata", prdata[1], 32'h0);
    chk("midrst_mem", getmem(1, 'h50), 32'h0);
    Rst = 1'b1;
    bus_idle(1);
    clear_model();
    pre = 32'hC0FFEE01;
    xfer(1, 1'b1, 16'h50, pre, 4'hF, 1'b0);
    xfer(1, 1'b0, 16'h50, 32'h0, 4'hF, 1'b1);
    bus_idle(1);
    cmp_mem(1, "post_rst_mem");
    cmp_mem(0, "post_rst_mem0");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
